// File: rtl/lsu_dmem_master_if.sv
// Bundle between the core's execute stage, the load/store unit and the
// word-organised data memory.
//
// Handshake: the core presents a request on req_i together with we_i,
// funct3_i, addr_i and wdata_i.  The request is taken on a rising clk edge
// where both req_i and ready_o are 1; at any other time req_i is ignored
// and nothing is queued.  Completion is a single-cycle done_o pulse with
// err_o qualified by it.  rdata_o holds the last load result from done_o
// until the next done_o.  The memory side has no handshake: reads are
// combinational from mem_addr_o, and a whole word is written at the rising
// edge of every cycle in which mem_we_o is 1.
interface lsu_dmem_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req_i;
  logic                  we_i;
  logic [2:0]            funct3_i;
  logic [ADDR_WIDTH-1:0] addr_i;
  logic [DATA_WIDTH-1:0] wdata_i;
  logic                  ready_o;
  logic                  done_o;
  logic                  err_o;
  logic [DATA_WIDTH-1:0] rdata_o;
  logic                  mem_we_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wd_o;
  logic [DATA_WIDTH-1:0] mem_rd_i;
  // FSM state for checkers: 0 IDLE, 1 ACCESS, 2 WRITE, 3 RESP
  logic [1:0]            dbg_state;

  // Load/store unit side
  modport master (
    input  req_i, we_i, funct3_i, addr_i, wdata_i, mem_rd_i,
    output ready_o, done_o, err_o, rdata_o,
    output mem_we_o, mem_addr_o, mem_wd_o, dbg_state
  );

  // Core plus data memory side
  modport slave (
    output req_i, we_i, funct3_i, addr_i, wdata_i, mem_rd_i,
    input  ready_o, done_o, err_o, rdata_o,
    input  mem_we_o, mem_addr_o, mem_wd_o, dbg_state
  );
endinterface

// File: rtl/lsu_dmem_master.sv
// RV32I load/store unit in front of a word-organised data memory.
// Loads: one ACCESS cycle reads the word, extracts and extends the
// byte/halfword. SW: one write cycle. SB/SH: read in ACCESS, merge, write
// the merged word in WRITE. Misaligned or illegal-width requests complete
// with err_o and never touch memory.
module lsu_dmem_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_i,
  lsu_dmem_master_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WRITE  = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [2:0]            funct3_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  we_q;

  logic                  req_err;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [DATA_WIDTH-1:0] ld_ext;
  logic [DATA_WIDTH-1:0] merged;

  assign bus.ready_o   = (state == IDLE);
  assign bus.dbg_state = state;

  // Classify an incoming request: illegal width code or misaligned address
  always_comb begin
    req_err = 1'b0;
    unique case (bus.funct3_i)
      F3_B, F3_BU: req_err = 1'b0;
      F3_H, F3_HU: req_err = bus.addr_i[0];
      F3_W:        req_err = (bus.addr_i[1:0] != 2'b00);
      default:     req_err = 1'b1;
    endcase
  end

  // Pick the addressed byte/halfword out of the read word and extend it
  always_comb begin
    ld_byte = 8'h00;
    ld_half = 16'h0000;
    ld_ext  = '0;
    unique case (addr_q[1:0])
      2'd0: ld_byte = bus.mem_rd_i[7:0];
      2'd1: ld_byte = bus.mem_rd_i[15:8];
      2'd2: ld_byte = bus.mem_rd_i[23:16];
      default: ld_byte = bus.mem_rd_i[31:24];
    endcase
    ld_half = addr_q[1] ? bus.mem_rd_i[31:16] : bus.mem_rd_i[15:0];
    unique case (funct3_q)
      F3_B:    ld_ext = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   ld_ext = {24'h000000, ld_byte};
      F3_H:    ld_ext = {{16{ld_half[15]}}, ld_half};
      F3_HU:   ld_ext = {16'h0000, ld_half};
      default: ld_ext = bus.mem_rd_i;
    endcase
  end

  // Build the read-modify-write word: the read word with the store lane
  // replaced. funct3[1:0] gives the store size (BU/HU codes act as B/H).
  always_comb begin
    merged = bus.mem_rd_i;
    if (funct3_q[1:0] == 2'b00) begin
      unique case (addr_q[1:0])
        2'd0: merged[7:0]   = wdata_q[7:0];
        2'd1: merged[15:8]  = wdata_q[7:0];
        2'd2: merged[23:16] = wdata_q[7:0];
        default: merged[31:24] = wdata_q[7:0];
      endcase
    end else if (addr_q[1]) begin
      merged[31:16] = wdata_q[15:0];
    end else begin
      merged[15:0] = wdata_q[15:0];
    end
  end

  // Control FSM; every bus output is registered on the transition into
  // the state that presents it, so reset clears them asynchronously.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state          <= IDLE;
      addr_q         <= '0;
      funct3_q       <= 3'b000;
      wdata_q        <= '0;
      we_q           <= 1'b0;
      bus.rdata_o    <= '0;
      bus.done_o     <= 1'b0;
      bus.err_o      <= 1'b0;
      bus.mem_we_o   <= 1'b0;
      bus.mem_addr_o <= '0;
      bus.mem_wd_o   <= '0;
    end else begin
      bus.done_o <= 1'b0;
      bus.err_o  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.req_i) begin
            addr_q   <= bus.addr_i;
            funct3_q <= bus.funct3_i;
            wdata_q  <= bus.wdata_i;
            we_q     <= bus.we_i;
            if (req_err) begin
              state      <= RESP;
              bus.done_o <= 1'b1;
              bus.err_o  <= 1'b1;
            end else begin
              state          <= ACCESS;
              bus.mem_addr_o <= {bus.addr_i[ADDR_WIDTH-1:2], 2'b00};
              // SW needs no read, so it writes during ACCESS
              if (bus.we_i && bus.funct3_i == F3_W) begin
                bus.mem_we_o <= 1'b1;
                bus.mem_wd_o <= bus.wdata_i;
              end
            end
          end
        end
        ACCESS: begin
          if (!we_q) begin
            bus.rdata_o    <= ld_ext;
            bus.mem_addr_o <= '0;
            bus.done_o     <= 1'b1;
            state          <= RESP;
          end else if (funct3_q == F3_W) begin
            bus.mem_we_o   <= 1'b0;
            bus.mem_wd_o   <= '0;
            bus.mem_addr_o <= '0;
            bus.done_o     <= 1'b1;
            state          <= RESP;
          end else begin
            // mem_wd_o doubles as the latched merged word for WRITE
            bus.mem_we_o <= 1'b1;
            bus.mem_wd_o <= merged;
            state        <= WRITE;
          end
        end
        WRITE: begin
          bus.mem_we_o   <= 1'b0;
          bus.mem_wd_o   <= '0;
          bus.mem_addr_o <= '0;
          bus.done_o     <= 1'b1;
          state          <= RESP;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
